// File: rtl/morse_text_scroll_if.sv
// Bundle between the Morse recognition stages and the text scroll stage.
// master drives strobes and the character code; slave returns the window and status.
`ifndef CHAR_W
`define CHAR_W 6
`endif
`ifndef CHAR_CODE_SPACE
`define CHAR_CODE_SPACE 6'd36
`endif

interface morse_text_scroll_if #(
    parameter int CHAR_W = `CHAR_W,
    parameter int WIN    = 6
);
    logic                  ce;
    logic                  clear;
    logic [CHAR_W-1:0]     char;
    logic                  char_end;
    logic                  word_end;
    logic                  error;
    logic                  scroll_back;
    logic                  scroll_fwd;
    logic [WIN*CHAR_W-1:0] win;
    logic [6:0]            count;
    logic [6:0]            offset;
    logic                  err_drop;

    modport master (
        output ce, clear, char, char_end, word_end, error, scroll_back, scroll_fwd,
        input  win, count, offset, err_drop
    );

    modport slave (
        input  ce, clear, char, char_end, word_end, error, scroll_back, scroll_fwd,
        output win, count, offset, err_drop
    );
endinterface

// File: rtl/morse_text_scroll.sv
// Decoded-text history with a scrollable WIN-slot window for the HEX digits.
// Optional auto-space insertion on word_end: define MORSE_TEXT_AUTOSPACE_EN.
`ifndef CHAR_W
`define CHAR_W 6
`endif
`ifndef CHAR_CODE_SPACE
`define CHAR_CODE_SPACE 6'd36
`endif

module morse_text_scroll #(
    parameter int DEPTH = 16,
    parameter int WIN   = 6
) (
    input logic                clk,
    input logic                rst,
    morse_text_scroll_if.slave bus
);
    localparam int              CW     = `CHAR_W;
    localparam logic [CW-1:0]   SPACE  = `CHAR_CODE_SPACE;
    localparam logic [6:0]      DEPTH7 = 7'(DEPTH);
    localparam logic [6:0]      WIN7   = 7'(WIN);

    logic [CW-1:0]     hist_q [DEPTH];
    logic [CW-1:0]     hist_d [DEPTH];
    logic [6:0]        count_q, count_d;
    logic [6:0]        offset_q, offset_d;
    logic [WIN*CW-1:0] win_q, win_d;
    logic              err_drop_q, err_drop_d;

    logic              do_char, do_space;
    logic [6:0]        max_off, cnt_sum, idx;

    always_comb begin
        do_char = bus.ce & bus.char_end & ~bus.error;
`ifdef MORSE_TEXT_AUTOSPACE_EN
        // Suppression looks at the newest entry as it will be after this cycle's character.
        do_space = bus.ce & bus.word_end & ((count_q != '0) | do_char)
                 & ((do_char ? bus.char : hist_q[0]) != SPACE);
`else
        do_space = 1'b0;
`endif
    end

`ifndef MORSE_TEXT_AUTOSPACE_EN
    logic unused_word_end;
    assign unused_word_end = bus.word_end;
`endif

    always_comb begin
        hist_d     = hist_q;
        count_d    = count_q;
        offset_d   = offset_q;
        err_drop_d = 1'b0;
        max_off    = (count_q > WIN7) ? count_q - WIN7 : '0;
        cnt_sum    = count_q + 7'(do_char) + 7'(do_space);
        if (bus.clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) hist_d[i] = SPACE;
            count_d  = '0;
            offset_d = '0;
        end else begin
            err_drop_d = bus.ce & bus.char_end & bus.error;
            if (do_char && do_space) begin
                for (int unsigned i = 2; i < DEPTH; i++) hist_d[i] = hist_q[i-2];
                hist_d[1] = bus.char;
                hist_d[0] = SPACE;
            end else if (do_char || do_space) begin
                for (int unsigned i = 1; i < DEPTH; i++) hist_d[i] = hist_q[i-1];
                hist_d[0] = do_char ? bus.char : SPACE;
            end
            if (do_char || do_space) begin
                count_d  = (cnt_sum > DEPTH7) ? DEPTH7 : cnt_sum;
                offset_d = '0;
            end else if (bus.ce) begin
                if (bus.scroll_back && !bus.scroll_fwd && offset_q < max_off)
                    offset_d = offset_q + 7'd1;
                else if (bus.scroll_fwd && !bus.scroll_back && offset_q != '0)
                    offset_d = offset_q - 7'd1;
            end
        end
    end

    // Window is built from registered state, so it trails count/offset by one cycle.
    always_comb begin
        win_d = {WIN{SPACE}};
        idx   = '0;
        for (int unsigned k = 0; k < WIN; k++) begin
            idx = offset_q + 7'(k);
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (idx == 7'(j) && idx < count_q) win_d[k*CW +: CW] = hist_q[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) hist_q[i] <= SPACE;
            count_q    <= '0;
            offset_q   <= '0;
            win_q      <= {WIN{SPACE}};
            err_drop_q <= 1'b0;
        end else begin
            hist_q     <= hist_d;
            count_q    <= count_d;
            offset_q   <= offset_d;
            win_q      <= win_d;
            err_drop_q <= err_drop_d;
        end
    end

    assign bus.win      = win_q;
    assign bus.count    = count_q;
    assign bus.offset   = offset_q;
    assign bus.err_drop = err_drop_q;
endmodule

// File: tb/tb_morse_text_scroll.sv
// Directed self-checking bench for morse_text_scroll (DEPTH=16, WIN=6, space code 36).
`ifndef CHAR_W
`define CHAR_W 6
`endif
`ifndef CHAR_CODE_SPACE
`define CHAR_CODE_SPACE 6'd36
`endif

module tb_morse_text_scroll;
    localparam int         WIN = 6;
    localparam logic [5:0] SP  = 6'd36;
    localparam logic [35:0] SP6 = {6{SP}};

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    morse_text_scroll_if #(.WIN(WIN)) bus ();

    morse_text_scroll #(.DEPTH(16), .WIN(WIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ce = 1'b1; bus.clear = 1'b0; bus.char = '0; bus.char_end = 1'b0;
        bus.word_end = 1'b0; bus.error = 1'b0; bus.scroll_back = 1'b0; bus.scroll_fwd = 1'b0;
    endtask

    task automatic push(input logic [5:0] c);
        bus.ce = 1'b1; bus.char = c; bus.char_end = 1'b1;
        tick();
        bus.char_end = 1'b0;
    endtask

    task automatic scroll(input logic b, input logic f, input logic en);
        bus.ce = en; bus.scroll_back = b; bus.scroll_fwd = f;
        tick();
        idle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check_eq("rst_count", 64'(bus.count), 64'd0);
        check_eq("rst_offset", 64'(bus.offset), 64'd0);
        check_eq("rst_win", 64'(bus.win), 64'(SP6));
        check_eq("rst_err_drop", 64'(bus.err_drop), 64'd0);

        // word_end on empty history never adds anything
        bus.word_end = 1'b1; tick(); bus.word_end = 1'b0; tick();
        check_eq("space_empty", 64'(bus.count), 64'd0);

        // S O S
        push(6'd28); push(6'd24); push(6'd28);
        check_eq("sos_count", 64'(bus.count), 64'd3);
        tick();
        check_eq("sos_win", 64'(bus.win), 64'({SP, SP, SP, 6'd28, 6'd24, 6'd28}));
        check_eq("sos_offset", 64'(bus.offset), 64'd0);
        scroll(1'b1, 1'b0, 1'b1);
        check_eq("back_short_hist", 64'(bus.offset), 64'd0);

        // errored character
        bus.char = 6'd14; bus.char_end = 1'b1; bus.error = 1'b1;
        tick();
        idle();
        check_eq("err_pulse", 64'(bus.err_drop), 64'd1);
        check_eq("err_count", 64'(bus.count), 64'd3);
        tick();
        check_eq("err_pulse_end", 64'(bus.err_drop), 64'd0);
        check_eq("err_win", 64'(bus.win), 64'({SP, SP, SP, 6'd28, 6'd24, 6'd28}));

        // char_end + word_end together, then a second word_end
        do_reset();
        bus.char = 6'd14; bus.char_end = 1'b1; bus.word_end = 1'b1;
        tick();
        bus.char_end = 1'b0;
        tick();
        bus.word_end = 1'b0;
        tick();
`ifdef MORSE_TEXT_AUTOSPACE_EN
        check_eq("dbl_count", 64'(bus.count), 64'd2);
        check_eq("dbl_win", 64'(bus.win), 64'({SP, SP, SP, SP, 6'd14, SP}));
`else
        check_eq("dbl_count", 64'(bus.count), 64'd1);
        check_eq("dbl_win", 64'(bus.win), 64'({SP, SP, SP, SP, SP, 6'd14}));
`endif

        // overflow and scroll limits
        do_reset();
        for (int i = 0; i < 20; i++) push(6'(i));
        check_eq("sat_count", 64'(bus.count), 64'd16);
        tick();
        check_eq("sat_win", 64'(bus.win), 64'({6'd14, 6'd15, 6'd16, 6'd17, 6'd18, 6'd19}));
        scroll(1'b0, 1'b1, 1'b1);
        check_eq("fwd_at_zero", 64'(bus.offset), 64'd0);
        for (int i = 0; i < 12; i++) scroll(1'b1, 1'b0, 1'b1);
        check_eq("back_limit", 64'(bus.offset), 64'd10);
        tick();
        check_eq("back_win", 64'(bus.win), 64'({6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9}));
        scroll(1'b0, 1'b1, 1'b1);
        check_eq("fwd_one", 64'(bus.offset), 64'd9);
        scroll(1'b1, 1'b0, 1'b0);
        scroll(1'b0, 1'b1, 1'b0);
        check_eq("scroll_ce0", 64'(bus.offset), 64'd9);
        scroll(1'b1, 1'b1, 1'b1);
        check_eq("scroll_both", 64'(bus.offset), 64'd9);
        push(6'd30);
        check_eq("push_follow", 64'(bus.offset), 64'd0);
        check_eq("push_sat", 64'(bus.count), 64'd16);
        tick();
        check_eq("push_win", 64'(bus.win), 64'({6'd15, 6'd16, 6'd17, 6'd18, 6'd19, 6'd30}));

        // clear wins over a same-cycle character
        for (int i = 0; i < 3; i++) scroll(1'b1, 1'b0, 1'b1);
        check_eq("pre_clear_off", 64'(bus.offset), 64'd3);
        bus.clear = 1'b1; bus.char = 6'd5; bus.char_end = 1'b1;
        tick();
        idle();
        check_eq("clr_count", 64'(bus.count), 64'd0);
        check_eq("clr_offset", 64'(bus.offset), 64'd0);
        tick();
        check_eq("clr_win", 64'(bus.win), 64'(SP6));

        // clear is not gated by ce
        push(6'd1); push(6'd2);
        bus.ce = 1'b0; bus.clear = 1'b1;
        tick();
        idle();
        check_eq("clr_ce0", 64'(bus.count), 64'd0);

        // reset during a scrolled view
        for (int i = 0; i < 8; i++) push(6'(i));
        for (int i = 0; i < 3; i++) scroll(1'b1, 1'b0, 1'b1);
        check_eq("scroll8_limit", 64'(bus.offset), 64'd2);
        tick();
        check_eq("scroll8_win", 64'(bus.win), 64'({6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5}));
        do_reset();
        check_eq("rst2_count", 64'(bus.count), 64'd0);
        check_eq("rst2_offset", 64'(bus.offset), 64'd0);
        tick();
        check_eq("rst2_win", 64'(bus.win), 64'(SP6));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
